// File: rtl/seven_segment_scanner.sv
// Multiplexed common-anode 7-segment driver: scans n_digits slots, blanks each slot's lead-in,
// and snapshots hex/dots/en once per full scan so a multi-digit value never tears.
module seven_segment_scanner #(
  parameter int n_digits     = 4,
  parameter int depth        = 16,
  parameter int blank_cycles = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [4*n_digits-1:0] hex,
  input  logic [n_digits-1:0]   dots,
  input  logic [n_digits-1:0]   en,
  output logic [7:0]            abcdefgh,
  output logic [n_digits-1:0]   digit,
  output logic                  scan_start
);

  localparam int                 idx_w     = $clog2(n_digits);
  localparam logic [depth-1:0]   blank_lim = depth'(blank_cycles);
  localparam logic [idx_w-1:0]   idx_last  = idx_w'(n_digits - 1);
  localparam logic [n_digits-1:0] one_hot0 = n_digits'(1);

  logic [depth-1:0]      cnt_q, cnt_d;
  logic [idx_w-1:0]      idx_q, idx_d;
  logic [4*n_digits-1:0] hex_s_q, hex_s_d;
  logic [n_digits-1:0]   dots_s_q, dots_s_d;
  logic [n_digits-1:0]   en_s_q, en_s_d;
  logic [7:0]            abcdefgh_q, abcdefgh_d;
  logic [n_digits-1:0]   digit_q, digit_d;
  logic                  scan_start_q, scan_start_d;

  logic       snap;
  logic       lit;
  logic [3:0] cur_hex;
  logic       cur_dot;
  logic       cur_en;

  // Active-high segment pattern, a in bit 6 down to g in bit 0.
  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0:    seg = 7'b1111110;
      4'h1:    seg = 7'b0110000;
      4'h2:    seg = 7'b1101101;
      4'h3:    seg = 7'b1111001;
      4'h4:    seg = 7'b0110011;
      4'h5:    seg = 7'b1011011;
      4'h6:    seg = 7'b1011111;
      4'h7:    seg = 7'b1110000;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1111011;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b0011111;
      4'hC:    seg = 7'b1001110;
      4'hD:    seg = 7'b0111101;
      4'hE:    seg = 7'b1001111;
      default: seg = 7'b1000111;
    endcase
  endfunction

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == '1) begin
      idx_d = (idx_q == idx_last) ? '0 : idx_q + 1'b1;
    end

    snap     = (cnt_q == '0) && (idx_q == '0);
    hex_s_d  = snap ? hex  : hex_s_q;
    dots_s_d = snap ? dots : dots_s_q;
    en_s_d   = snap ? en   : en_s_q;

    cur_hex = 4'h0;
    cur_dot = 1'b0;
    cur_en  = 1'b0;
    for (int k = 0; k < n_digits; k++) begin
      if (idx_q == idx_w'(k)) begin
        cur_hex = hex_s_q[4*k +: 4];
        cur_dot = dots_s_q[k];
        cur_en  = en_s_q[k];
      end
    end

    // The blank window at the head of every slot is what keeps the old digit's
    // segments from ghosting onto the newly selected anode.
    lit          = cur_en && (cnt_q >= blank_lim);
    digit_d      = lit ? ~(one_hot0 << idx_q) : '1;
    abcdefgh_d   = lit ? ~{seg(cur_hex), cur_dot} : 8'hFF;
    scan_start_d = snap;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      hex_s_q      <= '0;
      dots_s_q     <= '0;
      en_s_q       <= '0;
      abcdefgh_q   <= 8'hFF;
      digit_q      <= '1;
      scan_start_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      hex_s_q      <= hex_s_d;
      dots_s_q     <= dots_s_d;
      en_s_q       <= en_s_d;
      abcdefgh_q   <= abcdefgh_d;
      digit_q      <= digit_d;
      scan_start_q <= scan_start_d;
    end
  end

  assign abcdefgh   = abcdefgh_q;
  assign digit      = digit_q;
  assign scan_start = scan_start_q;

endmodule
